// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_port_arbiter                                             |
// | Description : Shares one memory port between a data requester (D) and an  |
// |               instruction-fetch requester (I). One access is in flight at |
// |               a time. D normally wins. I is forced through once D has won |
// |               MAX_D_STREAK grants in a row while I was waiting. An access |
// |               that gets no mem_done within TIMEOUT WAIT cycles is aborted |
// |               and acked with err=1.                                        |
// |                                                                            |
// | Ports       : clk, rst             clock, synchronous active-high reset   |
// |               d_req/d_we/d_addr/d_wdata  data-side request                 |
// |               i_req/i_addr         instruction fetch request (read only)  |
// |               mem_done/mem_rdata   shared memory completion + read data   |
// |               mem_en/mem_we/mem_addr/mem_wdata  shared memory access      |
// |               split_en/split_sel   D/I splitter control (sel 1 = I path)  |
// |               d_ack/i_ack/rdata/err  completion pulses, data, timeout     |
// |                                                                            |
// | Revision    : 1.0  initial release                                        |
// +----------------------------------------------------------------------------+
module mem_port_arbiter #(
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 8,
    parameter int MAX_D_STREAK = 4,
    parameter int TIMEOUT      = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic                  mem_done,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  split_en,
    output logic                  split_sel,
    output logic                  d_ack,
    output logic                  i_ack,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  err
);

    // Widths are kept at least one bit so degenerate parameter values still elaborate.
    localparam int c_cnt_w    = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam int c_streak_w = (MAX_D_STREAK < 1) ? 1 : $clog2(MAX_D_STREAK + 1);

    localparam logic [c_cnt_w-1:0]    c_timeout    = c_cnt_w'(TIMEOUT);
    localparam logic [c_cnt_w-1:0]    c_cnt_one    = c_cnt_w'(1);
    localparam logic [c_streak_w-1:0] c_max_streak = c_streak_w'(MAX_D_STREAK);
    localparam logic [c_streak_w-1:0] c_streak_one = c_streak_w'(1);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_issue = 2'd1;
    localparam logic [1:0] c_st_wait  = 2'd2;
    localparam logic [1:0] c_st_done  = 2'd3;

    logic [1:0]            r_state;
    logic [c_streak_w-1:0] r_streak;
    logic [c_cnt_w-1:0]    r_cnt;
    logic                  r_owner;      // 0 = data side, 1 = instruction side
    logic                  r_mem_en;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic                  r_split_en;
    logic                  r_d_ack;
    logic                  r_i_ack;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_err;

    logic                  w_any_req;
    logic                  w_grant_i;
    logic [c_streak_w-1:0] w_streak_next;
    logic [c_cnt_w-1:0]    w_cnt_inc;

    assign w_any_req = d_req | i_req;

    // Instruction side wins when it is alone, or when it has already watched
    // the data side take MAX_D_STREAK grants in a row.
    assign w_grant_i = i_req & (~d_req | (r_streak == c_max_streak));

    // The streak only grows while an instruction fetch is being held off;
    // any instruction grant, or a data grant with nobody waiting, restarts it.
    always_comb begin
        w_streak_next = '0;
        if (!w_grant_i && i_req) begin
            if (r_streak == c_max_streak) begin
                w_streak_next = r_streak;
            end else begin
                w_streak_next = r_streak + c_streak_one;
            end
        end
    end

    assign w_cnt_inc = r_cnt + c_cnt_one;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_streak    <= '0;
            r_cnt       <= '0;
            r_owner     <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_split_en  <= 1'b0;
            r_d_ack     <= 1'b0;
            r_i_ack     <= 1'b0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
        end else begin
            // Strobes default low; each is raised for exactly one cycle below.
            r_mem_en <= 1'b0;
            r_d_ack  <= 1'b0;
            r_i_ack  <= 1'b0;

            case (r_state)
                c_st_idle: begin
                    if (w_any_req) begin
                        r_owner    <= w_grant_i;
                        r_streak   <= w_streak_next;
                        r_cnt      <= '0;
                        r_mem_en   <= 1'b1;
                        r_split_en <= 1'b1;
                        if (w_grant_i) begin
                            r_mem_we    <= 1'b0;
                            r_mem_addr  <= i_addr;
                            r_mem_wdata <= '0;
                        end else begin
                            r_mem_we    <= d_we;
                            r_mem_addr  <= d_addr;
                            r_mem_wdata <= d_wdata;
                        end
                        r_state <= c_st_issue;
                    end
                end

                c_st_issue: begin
                    r_cnt   <= '0;
                    r_state <= c_st_wait;
                end

                c_st_wait: begin
                    // mem_done is checked first so a completion on the final
                    // timeout cycle is still reported as a good access.
                    if (mem_done) begin
                        r_rdata    <= mem_rdata;
                        r_err      <= 1'b0;
                        r_split_en <= 1'b0;
                        r_d_ack    <= ~r_owner;
                        r_i_ack    <= r_owner;
                        r_state    <= c_st_done;
                    end else if (w_cnt_inc == c_timeout) begin
                        r_cnt      <= w_cnt_inc;
                        r_rdata    <= '0;
                        r_err      <= 1'b1;
                        r_split_en <= 1'b0;
                        r_d_ack    <= ~r_owner;
                        r_i_ack    <= r_owner;
                        r_state    <= c_st_done;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end

                c_st_done: begin
                    // Ack is visible this cycle; no new grant until back in idle.
                    r_state <= c_st_idle;
                end

                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign split_en  = r_split_en;
    assign split_sel = r_owner;
    assign d_ack     = r_d_ack;
    assign i_ack     = r_i_ack;
    assign rdata     = r_rdata;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mem_port_arbiter                                          |
// | Description : Directed self-checking bench for mem_port_arbiter. Inputs   |
// |               are driven and outputs sampled on the falling clock edge.   |
// | Revision    : 1.0  initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [7:0]  d_wdata;
    logic        i_req;
    logic [15:0] i_addr;
    logic        mem_done;
    logic [7:0]  mem_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        split_en;
    logic        split_sel;
    logic        d_ack;
    logic        i_ack;
    logic [7:0]  rdata;
    logic        err;

    int n_tests;
    int n_fail;

    mem_port_arbiter #(
        .ADDR_WIDTH   (16),
        .DATA_WIDTH   (8),
        .MAX_D_STREAK (4),
        .TIMEOUT      (15)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .mem_done  (mem_done),
        .mem_rdata (mem_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .split_en  (split_en),
        .split_sel (split_sel),
        .d_ack     (d_ack),
        .i_ack     (i_ack),
        .rdata     (rdata),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // Advances until mem_en is seen, with a bounded number of cycles.
    task automatic wait_mem_en(input string tag);
        int n;
        n = 0;
        while (mem_en !== 1'b1 && n < 8) begin
            cyc();
            n++;
        end
        check(tag, mem_en, 1);
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_mem_en"},    mem_en,    0);
        check({pfx, "_split_en"},  split_en,  0);
        check({pfx, "_split_sel"}, split_sel, 0);
        check({pfx, "_d_ack"},     d_ack,     0);
        check({pfx, "_i_ack"},     i_ack,     0);
        check({pfx, "_err"},       err,       0);
        check({pfx, "_rdata"},     rdata,     0);
        check({pfx, "_mem_addr"},  mem_addr,  0);
        check({pfx, "_mem_we"},    mem_we,    0);
        check({pfx, "_mem_wdata"}, mem_wdata, 0);
    endtask

    initial begin
        logic [9:0] grant_order;
        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b1;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_addr    = '0;
        d_wdata   = '0;
        i_req     = 1'b0;
        i_addr    = '0;
        mem_done  = 1'b0;
        mem_rdata = '0;

        // Reset values
        cyc();
        cyc();
        check_reset_outputs("rst");
        rst = 1'b0;

        // Single data read, minimum latency
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 16'h0010;
        cyc();                                   // ISSUE (N+1)
        check("rd_mem_en",    mem_en,    1);
        check("rd_split_en",  split_en,  1);
        check("rd_split_sel", split_sel, 0);
        check("rd_mem_addr",  mem_addr,  16'h0010);
        check("rd_mem_we",    mem_we,    0);
        cyc();                                   // WAIT (N+2)
        check("rd_mem_en_1cyc", mem_en, 0);
        check("rd_wait_split",  split_en, 1);
        mem_done  = 1'b1;
        mem_rdata = 8'h5A;
        cyc();                                   // DONE (N+3)
        mem_done = 1'b0;
        d_req    = 1'b0;
        check("rd_d_ack",      d_ack,    1);
        check("rd_i_ack",      i_ack,    0);
        check("rd_rdata",      rdata,    8'h5A);
        check("rd_err",        err,      0);
        check("rd_done_split", split_en, 0);
        cyc();
        check("rd_ack_pulse",  d_ack,    0);

        // Both requesters held: D x4 then I, twice
        grant_order = 10'b10000_10000;           // bit k = 1 means I expected
        d_req     = 1'b1;
        d_we      = 1'b0;
        d_addr    = 16'h0020;
        i_req     = 1'b1;
        i_addr    = 16'h0300;
        mem_rdata = 8'hA5;
        for (int k = 0; k < 10; k++) begin
            wait_mem_en($sformatf("arb%0d_mem_en", k));
            check($sformatf("arb%0d_sel", k), split_sel, grant_order[k]);
            cyc();
            mem_done = 1'b1;
            cyc();
            mem_done = 1'b0;
            check($sformatf("arb%0d_d_ack", k), d_ack, !grant_order[k]);
            check($sformatf("arb%0d_i_ack", k), i_ack, grant_order[k]);
        end
        d_req = 1'b0;
        i_req = 1'b0;
        cyc();

        // Instruction fetch timeout; also confirms fetch forces we=0, wdata=0
        i_req   = 1'b1;
        i_addr  = 16'h1234;
        d_we    = 1'b1;
        d_wdata = 8'hFF;
        cyc();                                   // ISSUE
        check("to_mem_en",    mem_en,    1);
        check("to_split_sel", split_sel, 1);
        check("to_mem_addr",  mem_addr,  16'h1234);
        check("to_mem_we",    mem_we,    0);
        check("to_mem_wdata", mem_wdata, 0);
        for (int w = 1; w <= 15; w++) begin
            cyc();                               // WAIT cycle w
        end
        check("to_no_early_ack", i_ack,    0);
        check("to_wait15_split", split_en, 1);
        cyc();                                   // DONE
        i_req = 1'b0;
        check("to_i_ack", i_ack,    1);
        check("to_d_ack", d_ack,    0);
        check("to_err",   err,      1);
        check("to_rdata", rdata,    0);
        check("to_split", split_en, 0);
        cyc();
        check("to_ack_pulse", i_ack, 0);

        // mem_done on the final timeout cycle wins
        i_req = 1'b1;
        cyc();                                   // ISSUE
        check("co_mem_en", mem_en, 1);
        for (int w = 1; w <= 15; w++) begin
            cyc();
        end
        mem_done  = 1'b1;
        mem_rdata = 8'h3C;
        cyc();                                   // DONE
        mem_done = 1'b0;
        i_req    = 1'b0;
        check("co_i_ack", i_ack, 1);
        check("co_err",   err,   0);
        check("co_rdata", rdata, 8'h3C);
        cyc();

        // Reset during WAIT of a data write, with a fetch pending
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 16'hBEEF;
        d_wdata = 8'h77;
        cyc();                                   // ISSUE
        check("rw_mem_we",    mem_we,    1);
        check("rw_mem_wdata", mem_wdata, 8'h77);
        check("rw_mem_addr",  mem_addr,  16'hBEEF);
        cyc();                                   // WAIT 1
        i_req  = 1'b1;
        i_addr = 16'h0400;
        cyc();                                   // WAIT 2
        rst = 1'b1;
        cyc();
        check_reset_outputs("rw");
        rst   = 1'b0;
        d_req = 1'b0;
        cyc();                                   // ISSUE for the fetch
        check("rw_i_mem_en",   mem_en,    1);
        check("rw_i_sel",      split_sel, 1);
        check("rw_i_addr",     mem_addr,  16'h0400);
        check("rw_no_d_ack",   d_ack,     0);
        cyc();
        mem_done  = 1'b1;
        mem_rdata = 8'h11;
        cyc();                                   // DONE
        mem_done = 1'b0;
        i_req    = 1'b0;
        check("rw_i_ack",  i_ack, 1);
        check("rw_d_ack2", d_ack, 0);
        check("rw_rdata",  rdata, 8'h11);
        cyc();

        // Requester drops after ISSUE; stray mem_done in IDLE
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 16'h0022;
        cyc();                                   // ISSUE
        check("dr_mem_en", mem_en, 1);
        d_req = 1'b0;
        cyc();                                   // WAIT 1
        cyc();                                   // WAIT 2
        cyc();                                   // WAIT 3
        mem_done  = 1'b1;
        mem_rdata = 8'h99;
        cyc();                                   // DONE
        mem_done = 1'b0;
        check("dr_d_ack",    d_ack,    1);
        check("dr_rdata",    rdata,    8'h99);
        check("dr_mem_addr", mem_addr, 16'h0022);
        cyc();                                   // IDLE
        check("dr_ack_once", d_ack, 0);
        mem_done  = 1'b1;
        mem_rdata = 8'hEE;
        cyc();
        mem_done = 1'b0;
        check("st_d_ack",  d_ack,  0);
        check("st_i_ack",  i_ack,  0);
        check("st_mem_en", mem_en, 0);
        cyc();
        check("st_d_ack2", d_ack,  0);
        check("st_rdata",  rdata,  8'h99);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 16: address width of both requesters and the shared memory port.
REQ-002 Parameter DATA_WIDTH, default 8: read/write data width.
REQ-003 Parameter MAX_D_STREAK, default 4: consecutive data grants allowed while instruction request waits.
REQ-004 Parameter TIMEOUT, default 15: WAIT cycles before abort; counter width ceil(log2(TIMEOUT+1)).
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 d_req  input  1  data-side request, held until d_ack.
REQ-008 d_we  input  1  data-side write (1) / read (0).
REQ-009 d_addr  input  ADDR_WIDTH  data-side address.
REQ-010 d_wdata  input  DATA_WIDTH  data-side write data.
REQ-011 i_req  input  1  instruction-fetch request (read only), held until i_ack.
REQ-012 i_addr  input  ADDR_WIDTH  fetch address.
REQ-013 mem_done  input  1  shared memory completion strobe.
REQ-014 mem_rdata  input  DATA_WIDTH  shared memory read data, valid with mem_done.
REQ-015 mem_en  output  1  one-cycle access start strobe.
REQ-016 mem_we, mem_addr, mem_wdata  output  1/ADDR_WIDTH/DATA_WIDTH  latched access fields.
REQ-017 split_en, split_sel  output  1/1  drive D/I splitter; split_sel 0 = data path, 1 = instruction path.
REQ-018 d_ack, i_ack  output  1/1  one-cycle completion pulses; rdata  output  DATA_WIDTH  returned data; err  output  1  timeout flag, valid with ack.

Function
REQ-019 FSM states SHALL be IDLE, ISSUE, WAIT, DONE; exactly one transaction in flight.
REQ-020 IDLE: if any request, pick winner, latch we/addr/wdata (i side: we=0, wdata=0), record owner, go ISSUE; else stay.
REQ-021 Arbitration: data wins unless i_req=1 and streak==MAX_D_STREAK, then instruction wins; lone requester always wins.
REQ-022 Streak counter: increments (saturating at MAX_D_STREAK) on data grant with i_req=1; clears on instruction grant or data grant with i_req=0.
REQ-023 ISSUE: mem_en=1 for exactly this cycle, split_en=1, split_sel=owner; go WAIT; timeout counter cleared.
REQ-024 WAIT: split_en=1, split_sel=owner held; on mem_done capture mem_rdata into rdata, err=0, go DONE; else counter increments, and when counter reaches TIMEOUT go DONE with err=1, rdata=0.
REQ-025 mem_done and final timeout count in same cycle: mem_done wins, err=0.
REQ-026 mem_done outside WAIT SHALL be ignored.
REQ-027 DONE: owner's ack=1 for one cycle, other ack=0, rdata/err stable, split_en=0; go IDLE; no new grant this cycle.
REQ-028 Minimum latency: request sampled in IDLE at cycle N -> mem_en at N+1 -> mem_done earliest N+2 -> ack at N+3.
REQ-029 Requester dropping req mid-transaction SHALL NOT abort it; ack still pulses.
REQ-030 mem_addr/mem_we/mem_wdata SHALL stay constant from ISSUE through DONE.

Reset
REQ-031 rst=1 at a clock edge: state IDLE, streak=0, counter=0; mem_en=0, split_en=0, split_sel=0, d_ack=0, i_ack=0, err=0, rdata=0, mem_addr/mem_we/mem_wdata=0.
REQ-032 rst mid-transaction SHALL abandon it with no ack; arbitration restarts in IDLE next cycle.

Verification
REQ-033 d_req only, d_addr=0x0010, d_we=0, mem_done 1 cycle after mem_en, mem_rdata=0x5A -> split_sel=0, d_ack at N+3, rdata=0x5A, err=0.
REQ-034 d_req and i_req held continuously, MAX_D_STREAK=4 -> grant order D,D,D,D,I,D,D,D,D,I.
REQ-035 i_req, memory never answers -> after 15 WAIT cycles i_ack=1, err=1, rdata=0.
REQ-036 mem_done coincident with timeout cycle 15 -> ack with err=0, rdata=mem_rdata.
REQ-037 rst during WAIT of a data write -> no d_ack, all outputs at reset values next cycle, pending i_req granted afterwards.
REQ-038 d_req dropped after ISSUE, mem_done later -> d_ack still pulses once; stray mem_done in IDLE -> no ack.
